// File: rtl/ip_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ip_tx_arbiter
//  Purpose  : Round-robin, frame-granular arbiter for a shared IP TX
//             header + payload port, with a payload-stall abort watchdog.
//  Revision : 1.0
// ============================================================================
module ip_tx_arbiter #(
  parameter int N_SRC   = 2,
  parameter int HDR_W   = 104,
  parameter int TIMEOUT = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [N_SRC-1:0]                       s_hdr_valid,
  output logic [N_SRC-1:0]                       s_hdr_ready,
  input  logic [N_SRC*HDR_W-1:0]                 s_hdr,
  input  logic [N_SRC*8-1:0]                     s_tdata,
  input  logic [N_SRC-1:0]                       s_tvalid,
  output logic [N_SRC-1:0]                       s_tready,
  input  logic [N_SRC-1:0]                       s_tlast,
  output logic                                   m_hdr_valid,
  input  logic                                   m_hdr_ready,
  output logic [HDR_W-1:0]                       m_hdr,
  output logic [7:0]                             m_tdata,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic                                   m_tlast,
  output logic                                   m_tuser,
  output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] grant,
  output logic                                   busy,
  output logic                                   abort_pulse
);

  localparam int c_gw = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int c_ww = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_ww-1:0] c_wdog_limit = (TIMEOUT > 0) ? c_ww'(TIMEOUT - 1) : '0;
  localparam logic [c_ww-1:0] c_wdog_max   = '1;

  localparam logic [2:0] c_s_idle    = 3'd0;
  localparam logic [2:0] c_s_hdr     = 3'd1;
  localparam logic [2:0] c_s_payload = 3'd2;
  localparam logic [2:0] c_s_abort   = 3'd3;
  localparam logic [2:0] c_s_drain   = 3'd4;

  logic [2:0]       r_state;
  logic [c_gw-1:0]  r_grant;
  logic [c_gw-1:0]  r_last_grant;
  logic [c_ww-1:0]  r_wdog;
  logic             r_abort_pulse;

  logic [c_gw-1:0]  w_pick;
  logic             w_any;
  logic [N_SRC-1:0] w_gnt_oh;
  logic             w_sel_hvalid;
  logic [HDR_W-1:0] w_sel_hdr;
  logic             w_sel_tvalid;
  logic [7:0]       w_sel_tdata;
  logic             w_sel_tlast;
  logic             w_timeout;

  // Scan last_grant+1 .. last_grant+N_SRC; descending offsets so the nearest requester wins.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int i = N_SRC; i >= 1; i--) begin
      for (int j = 0; j < N_SRC; j++) begin
        if (s_hdr_valid[j] && (j == (int'(r_last_grant) + i) % N_SRC)) begin
          w_pick = c_gw'(j);
          w_any  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_gnt_oh     = '0;
    w_sel_hvalid = 1'b0;
    w_sel_hdr    = '0;
    w_sel_tvalid = 1'b0;
    w_sel_tdata  = '0;
    w_sel_tlast  = 1'b0;
    for (int j = 0; j < N_SRC; j++) begin
      if (r_grant == c_gw'(j)) begin
        w_gnt_oh[j]  = 1'b1;
        w_sel_hvalid = s_hdr_valid[j];
        w_sel_hdr    = s_hdr[j*HDR_W +: HDR_W];
        w_sel_tvalid = s_tvalid[j];
        w_sel_tdata  = s_tdata[j*8 +: 8];
        w_sel_tlast  = s_tlast[j];
      end
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_wdog == c_wdog_limit);

  always_comb begin
    m_hdr_valid = 1'b0;
    m_hdr       = '0;
    m_tvalid    = 1'b0;
    m_tdata     = '0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;
    s_hdr_ready = '0;
    s_tready    = '0;
    case (r_state)
      c_s_hdr: begin
        m_hdr_valid = w_sel_hvalid;
        m_hdr       = w_sel_hdr;
        s_hdr_ready = w_gnt_oh & {N_SRC{m_hdr_ready}};
      end
      c_s_payload: begin
        m_tvalid = w_sel_tvalid;
        m_tdata  = w_sel_tdata;
        m_tlast  = w_sel_tlast;
        s_tready = w_gnt_oh & {N_SRC{m_tready}};
      end
      c_s_abort: begin
        // Synthetic terminating beat: zero byte flagged for drop by the stack.
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
      end
      c_s_drain: begin
        s_tready = w_gnt_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= c_s_idle;
      r_grant       <= '0;
      r_last_grant  <= c_gw'(N_SRC - 1);
      r_wdog        <= '0;
      r_abort_pulse <= 1'b0;
    end else begin
      r_abort_pulse <= 1'b0;
      case (r_state)
        c_s_idle: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= c_s_hdr;
          end
        end
        c_s_hdr: begin
          if (w_sel_hvalid && m_hdr_ready) begin
            r_state <= c_s_payload;
            r_wdog  <= '0;
          end
        end
        c_s_payload: begin
          if (w_sel_tvalid && m_tready && w_sel_tlast) begin
            r_state      <= c_s_idle;
            r_last_grant <= r_grant;
            r_wdog       <= '0;
          end else if (w_sel_tvalid) begin
            // Sink backpressure with data pending is not a source stall.
            r_wdog <= '0;
          end else if (w_timeout) begin
            r_state <= c_s_abort;
            r_wdog  <= '0;
          end else if (r_wdog != c_wdog_max) begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        c_s_abort: begin
          if (m_tready) begin
            r_state       <= c_s_drain;
            r_abort_pulse <= 1'b1;
          end
        end
        c_s_drain: begin
          if (w_sel_tvalid && w_sel_tlast) begin
            r_state      <= c_s_idle;
            r_last_grant <= r_grant;
          end
        end
        default: r_state <= c_s_idle;
      endcase
    end
  end

  assign grant       = r_grant;
  assign busy        = (r_state != c_s_idle);
  assign abort_pulse = r_abort_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ip_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ip_tx_arbiter
//  Purpose  : Directed, scoreboard-checked bench for ip_tx_arbiter (3 sources).
//  Revision : 1.0
// ============================================================================
module tb_ip_tx_arbiter;

  localparam int N  = 3;
  localparam int HW = 104;
  localparam int TO = 16;

  typedef struct { int src; logic [HW-1:0] h; } hdr_t;
  typedef struct { int src; logic [7:0] d; logic last; logic user; } beat_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    s_hdr_valid, s_hdr_ready, s_tvalid, s_tready, s_tlast;
  logic [N*HW-1:0] s_hdr;
  logic [N*8-1:0]  s_tdata;
  logic            m_hdr_valid, m_hdr_ready, m_tvalid, m_tready, m_tlast, m_tuser;
  logic [HW-1:0]   m_hdr;
  logic [7:0]      m_tdata;
  logic [1:0]      grant;
  logic            busy, abort_pulse;

  logic          hv[N], tv[N], tl[N];
  logic [HW-1:0] hd[N];
  logic [7:0]    td[N];
  logic          kill = 1'b0;

  hdr_t  exp_hdr[$];
  beat_t exp_beat[$];
  int checks = 0, errors = 0, n_abort = 0, cyc = 0, last_beat_cyc = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int j = 0; j < N; j++) begin
      s_hdr_valid[j]       = hv[j];
      s_hdr[j*HW +: HW]    = hd[j];
      s_tdata[j*8 +: 8]    = td[j];
      s_tvalid[j]          = tv[j];
      s_tlast[j]           = tl[j];
    end
  end

  ip_tx_arbiter #(.N_SRC(N), .HDR_W(HW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_hdr(s_hdr),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready), .m_hdr(m_hdr),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .grant(grant), .busy(busy), .abort_pulse(abort_pulse)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] mkh(input int s, input int k);
    logic [87:0] mid;
    mid = 88'h0123456789abcdef001122;
    return {8'(s), mid, 8'(k)};
  endfunction

  task automatic expect_frame(input int s, input logic [HW-1:0] h, input int n, input logic [7:0] base);
    exp_hdr.push_back('{s, h});
    for (int i = 0; i < n; i++) exp_beat.push_back('{s, base + 8'(i), (i == n - 1), 1'b0});
  endtask

  task automatic drop(input int s);
    hv[s] = 1'b0; tv[s] = 1'b0; tl[s] = 1'b0;
  endtask

  // Source-side driver: header handshake, then n bytes with an optional tvalid gap.
  task automatic src_send(input int s, input logic [HW-1:0] h, input int n, input logic [7:0] base,
                          input int gap_at, input int gap_len);
    int budget;
    hd[s] = h; hv[s] = 1'b1; budget = 0;
    forever begin
      @(negedge clk);
      if (kill) begin drop(s); return; end
      if (s_hdr_ready[s]) break;
      budget++;
      if (budget >= 500) begin
        checks++;
        assert (budget < 500) else begin
          errors++; $error("FAIL hdr_wait src%0d: observed no handshake, expected one within 500 cycles", s);
        end
        drop(s); return;
      end
    end
    @(posedge clk); #1; hv[s] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin tv[s] = 1'b0; repeat (gap_len) @(posedge clk); #1; end
      td[s] = base + 8'(i); tl[s] = (i == n - 1); tv[s] = 1'b1; budget = 0;
      forever begin
        @(negedge clk);
        if (kill) begin drop(s); return; end
        if (s_tready[s]) break;
        budget++;
        if (budget >= 500) begin
          checks++;
          assert (budget < 500) else begin
            errors++; $error("FAIL byte_wait src%0d: observed no handshake, expected one within 500 cycles", s);
          end
          drop(s); return;
        end
      end
      @(posedge clk); #1;
    end
    tv[s] = 1'b0; tl[s] = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every accepted header and beat.
  always @(negedge clk) begin
    hdr_t  eh;
    beat_t eb;
    cyc++;
    if (reset_n) begin
      if (abort_pulse) n_abort++;
      if (m_hdr_valid && m_hdr_ready) begin
        checks++;
        assert (exp_hdr.size() > 0) else begin
          errors++; $error("FAIL hdr_extra: observed header %0h from grant %0d, expected none", m_hdr, grant);
        end
        if (exp_hdr.size() > 0) begin
          eh = exp_hdr.pop_front();
          chk("hdr", {grant, m_hdr}, {2'(eh.src), eh.h});
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        assert (exp_beat.size() > 0) else begin
          errors++; $error("FAIL beat_extra: observed byte %0h grant %0d, expected none", m_tdata, grant);
        end
        if (exp_beat.size() > 0) begin
          eb = exp_beat.pop_front();
          chk("beat", {grant, m_tdata, m_tlast, m_tuser}, {2'(eb.src), eb.d, eb.last, eb.user});
          if (eb.user) chk("abort_delay", 128'(cyc - last_beat_cyc), 128'(TO + 1));
        end
        last_beat_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    for (int j = 0; j < N; j++) begin
      hv[j] = 1'b0; tv[j] = 1'b0; tl[j] = 1'b0; hd[j] = '0; td[j] = '0;
    end
    m_hdr_ready = 1'b1; m_tready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_valids", {m_hdr_valid, m_tvalid, m_tlast, m_tuser, abort_pulse}, 0);
    chk("rst_readies", {s_hdr_ready, s_tready}, 0);
    chk("rst_data", {m_hdr, m_tdata}, 0);
    exp_hdr.delete(); exp_beat.delete();
    kill = 1'b0; n_abort = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic finish_test(input string tag, input int aborts);
    repeat (4) @(posedge clk); #1;
    chk({tag, "_hdr_left"}, exp_hdr.size(), 0);
    chk({tag, "_beat_left"}, exp_beat.size(), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_aborts"}, n_abort, aborts);
  endtask

  initial begin
    // 1: single source, 4 bytes, arbitration latency and busy release
    do_reset();
    expect_frame(0, mkh(0, 1), 4, 8'hA0);
    fork
      src_send(0, mkh(0, 1), 4, 8'hA0, -1, 0);
      begin
        @(negedge clk);
        chk("t1_hv_lat0", {m_hdr_valid, busy}, 2'b00);
        @(negedge clk);
        chk("t1_hv_lat1", {m_hdr_valid, busy, grant}, {1'b1, 1'b1, 2'd0});
      end
    join
    chk("t1_busy_done", busy, 0);
    finish_test("t1", 0);

    // 2: two continuous requesters alternate 0,1,0,1
    do_reset();
    expect_frame(0, mkh(0, 1), 3, 8'h10);
    expect_frame(1, mkh(1, 1), 3, 8'h20);
    expect_frame(0, mkh(0, 2), 3, 8'h30);
    expect_frame(1, mkh(1, 2), 3, 8'h40);
    fork
      begin src_send(0, mkh(0, 1), 3, 8'h10, -1, 0); src_send(0, mkh(0, 2), 3, 8'h30, -1, 0); end
      begin src_send(1, mkh(1, 1), 3, 8'h20, -1, 0); src_send(1, mkh(1, 2), 3, 8'h40, -1, 0); end
    join
    finish_test("t2", 0);

    // 3: sink toggles ready, source pauses below the limit; no abort
    do_reset();
    expect_frame(1, mkh(1, 3), 20, 8'h50);
    fork
      src_send(1, mkh(1, 3), 20, 8'h50, 5, TO - 4);
      for (int k = 0; k < 40; k++) begin @(posedge clk); #1; m_tready = ~m_tready; end
    join
    m_tready = 1'b1;
    finish_test("t3", 0);

    // 4: source stalls after 2 bytes -> abort beat, remaining 3 bytes drained silently
    do_reset();
    exp_hdr.push_back('{0, mkh(0, 4)});
    exp_beat.push_back('{0, 8'h60, 1'b0, 1'b0});
    exp_beat.push_back('{0, 8'h61, 1'b0, 1'b0});
    exp_beat.push_back('{0, 8'h00, 1'b1, 1'b1});
    src_send(0, mkh(0, 4), 5, 8'h60, 2, 25);
    finish_test("t4", 1);

    // 5: after source 0 was served, source 2 beats source 0
    do_reset();
    expect_frame(0, mkh(0, 5), 2, 8'h70);
    src_send(0, mkh(0, 5), 2, 8'h70, -1, 0);
    expect_frame(2, mkh(2, 6), 2, 8'h80);
    expect_frame(0, mkh(0, 6), 2, 8'h90);
    fork
      src_send(0, mkh(0, 6), 2, 8'h90, -1, 0);
      src_send(2, mkh(2, 6), 2, 8'h80, -1, 0);
    join
    finish_test("t5", 0);

    // 6: async reset mid-payload, then source 0 wins over source 1
    do_reset();
    expect_frame(0, mkh(0, 7), 2, 8'hB0);
    src_send(0, mkh(0, 7), 2, 8'hB0, -1, 0);
    expect_frame(0, mkh(0, 8), 30, 8'hC0);
    fork
      src_send(0, mkh(0, 8), 30, 8'hC0, -1, 0);
      begin
        repeat (8) @(posedge clk); #2;
        chk("t6_busy_before", {busy, m_tvalid, s_tready[0]}, 3'b111);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_busy_async", busy, 0);
        chk("t6_tvalid_async", m_tvalid, 0);
        chk("t6_tready_async", s_tready, 0);
        kill = 1'b1;
      end
    join
    do_reset();
    expect_frame(0, mkh(0, 9), 2, 8'hD0);
    expect_frame(1, mkh(1, 9), 2, 8'hE0);
    fork
      src_send(0, mkh(0, 9), 2, 8'hD0, -1, 0);
      src_send(1, mkh(1, 9), 2, 8'hE0, -1, 0);
    join
    finish_test("t6", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
